ifft_pingpong_ctrl: RTL and testbench
=====================================

// Module: ifft_pingpong_ctrl
// PURPOSE
//  Ping-pong buffer scheduler for the 16-point IFFT of the NB-IoT transmitter.
//  Accepts subcarrier samples from upstream and steers them into one of two
//  16-entry sample banks. Starts the IFFT core on each full bank and drives the
//  ifft_mux sel line so the core reads the bank not being written.
//  Sits between the resource-mapper output and the ifft_mux / IFFT core.
// PARAMETERS
//  N_POINTS  16  samples per IFFT frame (per bank)
//  ADDR_W    4   bank address width, log2(N_POINTS)
//  FCNT_W    8   width of completed-frame counter
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       upstream sample valid
//  in_ready     out  1       ready to accept a sample; transfer = in_valid & in_ready
//  wr_en        out  1       bank write strobe (= in_valid & in_ready)
//  wr_bank      out  1       bank targeted by the current write (0/1)
//  wr_addr      out  ADDR_W  write address within wr_bank
//  ifft_start   out  1       one-cycle start pulse to the IFFT core
//  ifft_done    in   1       one-cycle completion pulse from the IFFT core
//  mux_sel      out  1       to ifft_mux sel: bank read by the core (0 -> in_0, 1 -> in_1)
//  frame_cnt    out  FCNT_W  completed-frame count, wraps modulo 2^FCNT_W
//  proto_err    out  1       sticky: ifft_done received while no frame in flight
// BEHAVIOUR
//  Reset (async, rst_n=0): wr_bank=0, wr_addr=0, full[1:0]=0, rd_bank=0,
//   state=IDLE, ifft_start=0, mux_sel=0, frame_cnt=0, proto_err=0.
//   in_ready=1 during and after reset (both banks empty).
//  Write side:
//   in_ready = ~full[wr_bank] (combinational). wr_en, wr_bank and wr_addr are
//    presented in the handshake cycle.
//   On each handshake, wr_addr increments. When wr_addr=N_POINTS-1 is accepted:
//    full[wr_bank] sets, wr_bank toggles, wr_addr wraps to 0 (same edge).
//   Gaps in in_valid leave wr_addr unchanged; addresses are never skipped.
//  Read/scheduler FSM:
//   IDLE : if full[rd_bank] -> START; mux_sel <= rd_bank.
//   START: ifft_start=1 for exactly this cycle -> BUSY.
//   BUSY : wait for ifft_done; on it clear full[rd_bank], toggle rd_bank,
//          increment frame_cnt -> IDLE.
//   ifft_start is registered. It is high in the cycle beginning at the second
//    rising edge after the 16th-sample handshake, provided the FSM was in IDLE.
//   mux_sel updates only on the IDLE->START transition and is stable
//    from START through BUSY until the next frame.
//  Boundary conditions:
//   Both banks full: in_ready=0. Upstream stalls; no sample is dropped or overwritten.
//   Simultaneous set/clear: the 16th-sample fill of bank b and the ifft_done clear
//    of bank ~b in one cycle both take effect. in_ready follows the new wr_bank state.
//   Same-bank set and clear in one cycle cannot occur (a bank is read only when full).
//   ifft_done in IDLE or START: ignored for state, sets proto_err (cleared only by reset).
//   Frame order is strict: bank 0, 1, 0, 1, ...; rd_bank always trails wr_bank.
//   Reset mid-frame (any state) aborts all: partial bank contents discarded,
//    next accepted sample goes to bank 0 addr 0.
// TESTING
//  1 Reset, 16 back-to-back samples -> wr_addr 0..15 on bank 0, ifft_start one
//    pulse 2 clks after 16th, mux_sel=0, next sample goes to bank 1 addr 0.
//  2 Hold ifft_done low, send 40 samples -> in_ready drops after the 32nd handshake.
//    Pulse ifft_done -> in_ready=1 the next cycle, writes resume in bank 0 addr 0,
//    second ifft_start with mux_sel=1, frame_cnt=1.
//  3 ifft_done coincident with the 16th sample of the other bank -> both banks
//    update that edge, next ifft_start follows immediately, no stall cycle.
//  4 Random in_valid gaps (~50%) over 4 frames -> contiguous addresses, 4 start
//    pulses, frame_cnt=4 after 4 dones, bank order 0,1,0,1.
//  5 ifft_done pulsed in IDLE -> proto_err=1 and stays 1; state, full and
//    frame_cnt unchanged.
//  6 rst_n low after 7 samples while BUSY -> all outputs at reset values
//    asynchronously; next sample goes to bank 0 addr 0, and a late ifft_done
//    sets proto_err.

Source files
------------

// File: rtl/ifft_pingpong_ctrl.sv
// Ping-pong bank scheduler for the 16-point IFFT: steers upstream samples into two
// sample banks and launches the IFFT core on each full bank, reading the opposite one.
module ifft_pingpong_ctrl #(
    parameter int N_POINTS = 16,
    parameter int ADDR_W   = 4,
    parameter int FCNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              ifft_start,
    input  logic              ifft_done,
    output logic              mux_sel,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic                wr_bank_reg;
    logic                rd_bank_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [1:0]          full_reg, full_next;
    logic                mux_sel_reg;
    logic                start_reg;
    logic [FCNT_W-1:0]   frame_cnt_reg;
    logic                proto_err_reg;

    logic                last_sample;
    logic                fill;
    logic                launch;
    logic                clear;

    assign in_ready    = ~full_reg[wr_bank_reg];
    assign wr_en       = in_valid & in_ready;
    assign wr_bank     = wr_bank_reg;
    assign wr_addr     = wr_addr_reg;
    assign ifft_start  = start_reg;
    assign mux_sel     = mux_sel_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign proto_err   = proto_err_reg;

    assign last_sample = (wr_addr_reg == ADDR_W'(N_POINTS - 1));
    assign fill        = wr_en & last_sample;

    always_comb begin
        state_next = state_reg;
        launch     = 1'b0;
        clear      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (full_reg[rd_bank_reg]) begin
                    launch     = 1'b1;
                    state_next = START;
                end
            end
            START: state_next = BUSY;
            BUSY: begin
                if (ifft_done) begin
                    clear      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fill and clear always target different banks, so both may land on one edge.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            assign full_next[gi] = (full_reg[gi] | (fill & (wr_bank_reg == 1'(gi))))
                                 & ~(clear & (rd_bank_reg == 1'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            wr_addr_reg   <= '0;
            full_reg      <= 2'b00;
            mux_sel_reg   <= 1'b0;
            start_reg     <= 1'b0;
            frame_cnt_reg <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            full_reg  <= full_next;
            start_reg <= launch;
            if (launch) begin
                mux_sel_reg <= rd_bank_reg;
            end
            if (clear) begin
                rd_bank_reg   <= ~rd_bank_reg;
                frame_cnt_reg <= frame_cnt_reg + FCNT_W'(1);
            end
            // A completion with no frame in flight is a protocol violation.
            if (ifft_done && (state_reg != BUSY)) begin
                proto_err_reg <= 1'b1;
            end
            if (wr_en) begin
                if (last_sample) begin
                    wr_addr_reg <= '0;
                    wr_bank_reg <= ~wr_bank_reg;
                end else begin
                    wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ifft_pingpong_ctrl.sv
// Self-checking bench for ifft_pingpong_ctrl against a frame-counting reference model.
module tb_ifft_pingpong_ctrl;
    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       ifft_done = 1'b0;
    logic       in_ready, wr_en, wr_bank, ifft_start, mux_sel, proto_err;
    logic [3:0] wr_addr;
    logic [7:0] frame_cnt;

    int total = 0;
    int bad = 0;

    // Reference model: total samples accepted, frames started, frames completed.
    int m_acc, m_started, m_done;
    bit m_start_now, m_perr;

    ifft_pingpong_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .ifft_start(ifft_start),
        .ifft_done(ifft_done), .mux_sel(mux_sel), .frame_cnt(frame_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic exp_ready();
        return ((m_acc / N) - m_done) < 2;
    endfunction
    function automatic logic exp_bank();
        return 1'((m_acc / N) % 2);
    endfunction
    function automatic logic [3:0] exp_addr();
        return 4'(m_acc % N);
    endfunction
    function automatic logic exp_mux();
        return (m_started == 0) ? 1'b0 : 1'((m_started - 1) % 2);
    endfunction
    function automatic logic [7:0] exp_fcnt();
        return 8'(m_done % 256);
    endfunction
    function automatic bit m_busy();
        return (m_started > m_done) && !m_start_now;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_started = 0; m_done = 0; m_start_now = 0; m_perr = 0;
    endtask

    // Called just after a falling edge: present inputs and let them settle.
    task automatic set_in(input bit v, input bit d);
        in_valid  = v;
        ifft_done = d;
        #1;
    endtask

    // Update the model with the current inputs, then move through one rising edge.
    task automatic advance();
        bit hs, go;
        hs = in_valid && exp_ready();
        go = !m_start_now && (m_started == m_done) && ((m_acc / N) > m_started);
        if (ifft_done) begin
            if (m_busy()) m_done++;
            else m_perr = 1;
        end
        if (hs) m_acc++;
        m_start_now = go;
        if (go) m_started++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        ifft_done = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        ifft_done = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #12;
        total++;
        if ({in_ready, wr_en, wr_bank, wr_addr, ifft_start, mux_sel, frame_cnt, proto_err}
            !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%0b en=%0b bank=%0b addr=%0d st=%0b mux=%0b fc=%0d perr=%0b want 1 0 0 0 0 0 0 0",
                     in_ready, wr_en, wr_bank, wr_addr, ifft_start, mux_sel, frame_cnt, proto_err);
        end
        do_reset();
    endtask

    task automatic test_first_frame();
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_in(1, 0);
            total++;
            if ({wr_en, wr_bank, wr_addr} !== {1'b1, 1'b0, 4'(i)}) begin
                bad++;
                $display("FAIL t1_write[%0d] got en=%0b bank=%0b addr=%0d want en=1 bank=0 addr=%0d",
                         i, wr_en, wr_bank, wr_addr, i);
            end
            advance();
        end
        set_in(0, 0);
        total++;
        if (ifft_start !== 1'b0) begin
            bad++;
            $display("FAIL t1_start_early got=%0b want=0", ifft_start);
        end
        advance();
        total++;
        if ({ifft_start, mux_sel} !== {1'b1, 1'b0} || m_start_now !== 1'b1) begin
            bad++;
            $display("FAIL t1_start_pulse got st=%0b mux=%0b want st=1 mux=0", ifft_start, mux_sel);
        end
        advance();
        set_in(1, 0);
        total++;
        if ({ifft_start, wr_en, wr_bank, wr_addr} !== {1'b0, 1'b1, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL t1_next_bank got st=%0b en=%0b bank=%0b addr=%0d want st=0 en=1 bank=1 addr=0",
                     ifft_start, wr_en, wr_bank, wr_addr);
        end
        advance();
    endtask

    task automatic test_backpressure();
        int hs_cnt;
        do_reset();
        hs_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            set_in(1, 0);
            total++;
            if ({in_ready, wr_en, ifft_start} !== {exp_ready(), exp_ready(), m_start_now}) begin
                bad++;
                $display("FAIL t2_ready[%0d] got rdy=%0b en=%0b st=%0b want rdy=%0b st=%0b",
                         i, in_ready, wr_en, ifft_start, exp_ready(), m_start_now);
            end
            if (wr_en) hs_cnt++;
            advance();
        end
        set_in(0, 0);
        total++;
        if (hs_cnt !== 32 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL t2_stall got handshakes=%0d rdy=%0b want handshakes=32 rdy=0", hs_cnt, in_ready);
        end
        set_in(0, 1);
        advance();
        set_in(1, 0);
        total++;
        if ({in_ready, wr_en, wr_bank, wr_addr, frame_cnt} !== {1'b1, 1'b1, 1'b0, 4'd0, 8'd1}) begin
            bad++;
            $display("FAIL t2_resume got rdy=%0b en=%0b bank=%0b addr=%0d fc=%0d want 1 1 0 0 1",
                     in_ready, wr_en, wr_bank, wr_addr, frame_cnt);
        end
        advance();
        set_in(0, 0);
        total++;
        if ({ifft_start, mux_sel} !== {1'b1, 1'b1} || m_start_now !== 1'b1) begin
            bad++;
            $display("FAIL t2_second_start got st=%0b mux=%0b want st=1 mux=1", ifft_start, mux_sel);
        end
        advance();
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 2 * N; i++) begin
            set_in(1, (i == 2 * N - 1) ? 1'b1 : 1'b0);
            total++;
            if ({in_ready, wr_bank, wr_addr, ifft_start} !== {exp_ready(), exp_bank(), exp_addr(), m_start_now}) begin
                bad++;
                $display("FAIL t3_fill[%0d] got rdy=%0b bank=%0b addr=%0d st=%0b want rdy=%0b bank=%0b addr=%0d st=%0b",
                         i, in_ready, wr_bank, wr_addr, ifft_start, exp_ready(), exp_bank(), exp_addr(), m_start_now);
            end
            advance();
        end
        set_in(0, 0);
        total++;
        if ({in_ready, wr_bank, wr_addr, frame_cnt, ifft_start} !== {1'b1, 1'b0, 4'd0, 8'd1, 1'b0}) begin
            bad++;
            $display("FAIL t3_both_update got rdy=%0b bank=%0b addr=%0d fc=%0d st=%0b want 1 0 0 1 0",
                     in_ready, wr_bank, wr_addr, frame_cnt, ifft_start);
        end
        advance();
        total++;
        if ({ifft_start, mux_sel, proto_err} !== {1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL t3_immediate_start got st=%0b mux=%0b perr=%0b want st=1 mux=1 perr=0",
                     ifft_start, mux_sel, proto_err);
        end
        advance();
    endtask

    task automatic test_random_gaps();
        int starts, cyc;
        bit v, d;
        do_reset();
        starts = 0;
        cyc = 0;
        while (m_done < 4 && cyc < 3000) begin
            v = (m_acc < 4 * N) && ($urandom_range(0, 1) == 1);
            d = m_busy() && ($urandom_range(0, 3) == 0);
            set_in(v, d);
            total++;
            if ({in_ready, wr_en, wr_bank, wr_addr, ifft_start, mux_sel, frame_cnt, proto_err}
                !== {exp_ready(), v & exp_ready(), exp_bank(), exp_addr(), m_start_now, exp_mux(), exp_fcnt(), m_perr}) begin
                bad++;
                $display("FAIL t4_cycle[%0d] got rdy=%0b en=%0b bank=%0b addr=%0d st=%0b mux=%0b fc=%0d perr=%0b want %0b %0b %0b %0d %0b %0b %0d %0b",
                         cyc, in_ready, wr_en, wr_bank, wr_addr, ifft_start, mux_sel, frame_cnt, proto_err,
                         exp_ready(), v & exp_ready(), exp_bank(), exp_addr(), m_start_now, exp_mux(), exp_fcnt(), m_perr);
            end
            if (ifft_start === 1'b1) begin
                total++;
                if (mux_sel !== 1'(starts % 2)) begin
                    bad++;
                    $display("FAIL t4_bank_order start=%0d got mux=%0b want %0b", starts, mux_sel, starts % 2);
                end
                starts++;
            end
            advance();
            cyc++;
        end
        set_in(0, 0);
        total++;
        if (m_done != 4 || starts !== 4 || frame_cnt !== 8'd4) begin
            bad++;
            $display("FAIL t4_summary got starts=%0d fc=%0d model_done=%0d want starts=4 fc=4 done=4",
                     starts, frame_cnt, m_done);
        end
    endtask

    task automatic test_proto_err();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0);
            advance();
        end
        set_in(0, 1);
        advance();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0);
            total++;
            if ({proto_err, ifft_start, frame_cnt, in_ready, wr_addr} !== {1'b1, 1'b0, 8'd0, 1'b1, 4'd5} || !m_perr) begin
                bad++;
                $display("FAIL t5_sticky[%0d] got perr=%0b st=%0b fc=%0d rdy=%0b addr=%0d want 1 0 0 1 5",
                         i, proto_err, ifft_start, frame_cnt, in_ready, wr_addr);
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < N + 2 + 7; i++) begin
            set_in((i < N || i >= N + 2) ? 1'b1 : 1'b0, 0);
            advance();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, wr_en, wr_bank, wr_addr, ifft_start, mux_sel, frame_cnt, proto_err}
            !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL t6_async_reset got rdy=%0b en=%0b bank=%0b addr=%0d st=%0b mux=%0b fc=%0d perr=%0b want 1 0 0 0 0 0 0 0",
                     in_ready, wr_en, wr_bank, wr_addr, ifft_start, mux_sel, frame_cnt, proto_err);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 0);
        total++;
        if ({wr_en, wr_bank, wr_addr} !== {1'b1, exp_bank(), exp_addr()} || exp_addr() != 0) begin
            bad++;
            $display("FAIL t6_restart got en=%0b bank=%0b addr=%0d want en=1 bank=0 addr=0", wr_en, wr_bank, wr_addr);
        end
        advance();
        set_in(0, 1);
        advance();
        set_in(0, 0);
        total++;
        if (proto_err !== 1'b1 || !m_perr) begin
            bad++;
            $display("FAIL t6_late_done got perr=%0b want 1", proto_err);
        end
        advance();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_frame();
        test_backpressure();
        test_simultaneous();
        test_random_gaps();
        test_proto_err();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
